// File: rtl/ucsbece154b_perf_pkg.sv
// Shared definitions for the performance-counter bank: FSM encoding and event bit positions.
package ucsbece154b_perf_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STOPPED = 2'd2
  } perf_state_t;

  localparam int unsigned EV_BRANCH    = 0;
  localparam int unsigned EV_BRANCH_OK = 1;
  localparam int unsigned EV_JUMP      = 2;
  localparam int unsigned EV_JUMP_OK   = 3;

  localparam int unsigned PC_W = 32;

endpackage

// File: rtl/ucsbece154b_sat_counter.sv
// Single event counter with sticky overflow; saturates or wraps depending on SATURATE.
module ucsbece154b_sat_counter #(
  parameter int unsigned WIDTH    = 32,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q,
  output logic             ovf
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q   <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
      if (&q) begin
        ovf <= 1'b1;
        if (!SATURATE) q <= '0;
      end else begin
        q <= q + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/ucsbece154b_perf_counters.sv
// Event-counter bank for the pipelined core: per-event counters plus a cycle counter,
// stop-on-PC trigger, shadow snapshot registers and sticky overflow flags.
module ucsbece154b_perf_counters
  import ucsbece154b_perf_pkg::*;
#(
  parameter  int unsigned NUM_EVENTS = 4,
  parameter  int unsigned CNT_WIDTH  = 32,
  parameter  bit          SATURATE   = 1'b1,
  localparam int unsigned SEL_W      = $clog2(NUM_EVENTS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic [PC_W-1:0]       pc_i,
  input  logic                  stop_en_i,
  input  logic [PC_W-1:0]       stop_pc_i,
  input  logic                  clear_i,
  input  logic                  snap_i,
  input  logic [SEL_W-1:0]      rd_sel_i,
  output logic [CNT_WIDTH-1:0]  rd_data_o,
  output logic                  snap_valid_o,
  output logic                  running_o,
  output logic                  stopped_o,
  output logic [NUM_EVENTS:0]   overflow_o
);

  perf_state_t state_q, state_d;

  logic                 count_c;
  logic                 hit_c;
  logic [NUM_EVENTS:0]  inc_c;
  logic [CNT_WIDTH-1:0] cnt_q    [NUM_EVENTS+1];
  logic [CNT_WIDTH-1:0] nxt_c    [NUM_EVENTS+1];
  logic [CNT_WIDTH-1:0] shadow_q [NUM_EVENTS+1];

  assign count_c = en_i && (state_q != STOPPED);
  assign hit_c   = count_c && stop_en_i && (pc_i == stop_pc_i);
  // Top bit drives the cycle counter.
  assign inc_c   = {count_c, event_i & {NUM_EVENTS{count_c}}};

  for (genvar k = 0; k <= NUM_EVENTS; k++) begin : g_cnt
    ucsbece154b_sat_counter #(
      .WIDTH    (CNT_WIDTH),
      .SATURATE (SATURATE)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (clear_i),
      .inc   (inc_c[k]),
      .q     (cnt_q[k]),
      .ovf   (overflow_o[k])
    );
  end

  // Post-increment values, used when a trigger hit auto-loads the shadows.
  always_comb begin
    for (int unsigned k = 0; k <= NUM_EVENTS; k++) begin
      nxt_c[k] = cnt_q[k];
      if (inc_c[k]) begin
        if (&cnt_q[k]) nxt_c[k] = SATURATE ? cnt_q[k] : '0;
        else           nxt_c[k] = cnt_q[k] + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear_i)                 state_d = IDLE;
    else if (state_q == STOPPED) state_d = STOPPED;
    else if (hit_c)              state_d = STOPPED;
    else if (count_c)            state_d = RUN;
    else                         state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      running_o    <= 1'b0;
      stopped_o    <= 1'b0;
      snap_valid_o <= 1'b0;
      for (int unsigned k = 0; k <= NUM_EVENTS; k++) shadow_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      running_o <= (state_d == RUN);
      stopped_o <= (state_d == STOPPED);
      if (clear_i) begin
        snap_valid_o <= 1'b0;
        for (int unsigned k = 0; k <= NUM_EVENTS; k++) shadow_q[k] <= '0;
      end else if (hit_c) begin
        snap_valid_o <= 1'b1;
        shadow_q     <= nxt_c;
      end else if (snap_i) begin
        snap_valid_o <= 1'b1;
        shadow_q     <= cnt_q;
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    if (rd_sel_i <= SEL_W'(NUM_EVENTS)) rd_data_o = shadow_q[rd_sel_i];
  end

endmodule

// File: tb/tb_ucsbece154b_perf_counters.sv
// Self-checking bench: three configurations (32b saturating, 4b saturating, 4b wrapping)
// share one stimulus stream and are compared against an arithmetic reference model.
module tb_ucsbece154b_perf_counters;

  logic        clk = 1'b0;
  logic        reset, en, stop_en, clear, snap;
  logic [3:0]  ev;
  logic [31:0] pc, stop_pc;
  logic [2:0]  rd_sel;

  logic [31:0] rd_m;
  logic [3:0]  rd_s, rd_w;
  logic [2:0]  run_v, stop_v, sv_v;
  logic [4:0]  ovf_v [3];

  int errors = 0;
  int checks = 0;

  // Model state (config 0: 32b sat, 1: 4b sat, 2: 4b wrap)
  int     cw  [3] = '{32, 4, 4};
  bit     cs  [3] = '{1'b1, 1'b1, 1'b0};
  longint m_cnt [3][5];
  longint m_sh  [3][5];
  bit     m_ovf [3][5];
  bit     m_sv, m_running, m_stopped;

  typedef struct {
    bit         en;
    logic [3:0] ev;
    bit         snap;
    bit         clr;
    logic [2:0] sel;
    bit         e_run;
    bit         e_sv;
    longint     e_rd;
  } vec_t;
  vec_t tbl [17];

  always #20 clk = ~clk;

  ucsbece154b_perf_counters #(.NUM_EVENTS(4), .CNT_WIDTH(32), .SATURATE(1'b1)) dut (
    .clk(clk), .reset(reset), .en_i(en), .event_i(ev), .pc_i(pc), .stop_en_i(stop_en),
    .stop_pc_i(stop_pc), .clear_i(clear), .snap_i(snap), .rd_sel_i(rd_sel), .rd_data_o(rd_m),
    .snap_valid_o(sv_v[0]), .running_o(run_v[0]), .stopped_o(stop_v[0]), .overflow_o(ovf_v[0]));

  ucsbece154b_perf_counters #(.NUM_EVENTS(4), .CNT_WIDTH(4), .SATURATE(1'b1)) dut_s (
    .clk(clk), .reset(reset), .en_i(en), .event_i(ev), .pc_i(pc), .stop_en_i(stop_en),
    .stop_pc_i(stop_pc), .clear_i(clear), .snap_i(snap), .rd_sel_i(rd_sel), .rd_data_o(rd_s),
    .snap_valid_o(sv_v[1]), .running_o(run_v[1]), .stopped_o(stop_v[1]), .overflow_o(ovf_v[1]));

  ucsbece154b_perf_counters #(.NUM_EVENTS(4), .CNT_WIDTH(4), .SATURATE(1'b0)) dut_w (
    .clk(clk), .reset(reset), .en_i(en), .event_i(ev), .pc_i(pc), .stop_en_i(stop_en),
    .stop_pc_i(stop_pc), .clear_i(clear), .snap_i(snap), .rd_sel_i(rd_sel), .rd_data_o(rd_w),
    .snap_valid_o(sv_v[2]), .running_o(run_v[2]), .stopped_o(stop_v[2]), .overflow_o(ovf_v[2]));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint get_rd(input int c);
    if (c == 0) return longint'(rd_m);
    if (c == 1) return longint'(rd_s);
    return longint'(rd_w);
  endfunction

  function automatic longint maxv(input int c);
    return (longint'(1) << cw[c]) - 1;
  endfunction

  // Reference: apply one clock edge's worth of the rules to the model.
  task automatic model_update();
    longint old [3][5];
    bit cnt_en, hit;
    if (reset || clear) begin
      for (int c = 0; c < 3; c++)
        for (int k = 0; k < 5; k++) begin
          m_cnt[c][k] = 0; m_sh[c][k] = 0; m_ovf[c][k] = 1'b0;
        end
      m_sv = 1'b0; m_running = 1'b0; m_stopped = 1'b0;
      return;
    end
    cnt_en = en && !m_stopped;
    hit    = cnt_en && stop_en && (pc == stop_pc);
    old    = m_cnt;
    if (cnt_en)
      for (int c = 0; c < 3; c++)
        for (int k = 0; k < 5; k++)
          if (k == 4 || ev[k]) begin
            if (m_cnt[c][k] == maxv(c)) begin
              m_ovf[c][k] = 1'b1;
              if (!cs[c]) m_cnt[c][k] = 0;
            end else begin
              m_cnt[c][k] = m_cnt[c][k] + 1;
            end
          end
    if (hit) begin
      m_sh = m_cnt; m_sv = 1'b1;
    end else if (snap) begin
      m_sh = old; m_sv = 1'b1;
    end
    if (hit) begin
      m_stopped = 1'b1; m_running = 1'b0;
    end else if (!m_stopped) begin
      m_running = cnt_en;
    end
  endtask

  task automatic model_check();
    for (int c = 0; c < 3; c++) begin
      logic [4:0] eo;
      for (int k = 0; k < 5; k++) eo[k] = m_ovf[c][k];
      chk($sformatf("running[%0d]", c), longint'(run_v[c]), longint'(m_running));
      chk($sformatf("stopped[%0d]", c), longint'(stop_v[c]), longint'(m_stopped));
      chk($sformatf("snap_valid[%0d]", c), longint'(sv_v[c]), longint'(m_sv));
      chk($sformatf("overflow[%0d]", c), longint'(ovf_v[c]), longint'(eo));
    end
    for (int s = 0; s < 8; s++) begin
      rd_sel = 3'(s);
      #1;
      for (int c = 0; c < 3; c++)
        chk($sformatf("rd_data[%0d] sel%0d", c, s), get_rd(c), (s <= 4) ? m_sh[c][s] : 0);
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic rd_chk(input string name, input int c, input int sel, input longint exp);
    rd_sel = 3'(sel);
    #1;
    chk(name, get_rd(c), exp);
  endtask

  task automatic idle_inputs();
    en = 1'b0; ev = '0; snap = 1'b0; clear = 1'b0; stop_en = 1'b0; reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 5; i++) tbl[i] = '{1'b1, 4'b0011, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 0};
    tbl[5]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 5};
    tbl[6]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 5};
    tbl[7]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 0};
    tbl[8]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 5};
    tbl[9]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 3'd5, 1'b0, 1'b1, 0};
    tbl[10] = '{1'b1, 4'b0100, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 0};
    tbl[11] = '{1'b0, 4'b0100, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 0};
    tbl[12] = '{1'b0, 4'b0100, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 0};
    tbl[13] = '{1'b1, 4'b0100, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 0};
    tbl[14] = '{1'b0, 4'b0100, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 2};
    tbl[15] = '{1'b1, 4'b1111, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 0};
    tbl[16] = '{1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 0};

    idle_inputs();
    pc = '0; stop_pc = '0; rd_sel = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("reset running", longint'(run_v[0]), 0);
    chk("reset snap_valid", longint'(sv_v[0]), 0);

    // Directed table: basic counting, snapshot, en toggling, clear priority
    for (int i = 0; i < 17; i++) begin
      en = tbl[i].en; ev = tbl[i].ev; snap = tbl[i].snap; clear = tbl[i].clr;
      step();
      chk($sformatf("tbl%0d running", i), longint'(run_v[0]), longint'(tbl[i].e_run));
      chk($sformatf("tbl%0d snap_valid", i), longint'(sv_v[0]), longint'(tbl[i].e_sv));
      rd_chk($sformatf("tbl%0d rd_data", i), 0, int'(tbl[i].sel), tbl[i].e_rd);
    end
    idle_inputs();

    // Stop-on-PC: hit on run cycle 20, events after the hit ignored
    clear = 1'b1; step(); clear = 1'b0;
    stop_pc = 32'h0001_0068; stop_en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      en = 1'b1; ev = 4'b0001; pc = stop_pc - 32'(4 * (20 - i));
      step();
    end
    chk("stop stopped", longint'(stop_v[0]), 1);
    chk("stop snap_valid", longint'(sv_v[0]), 1);
    rd_chk("stop cycles", 0, 4, 20);
    rd_chk("stop ev0", 0, 0, 20);
    for (int i = 0; i < 3; i++) begin ev = 4'b1111; pc = stop_pc; step(); end
    en = 1'b0; ev = '0; snap = 1'b1; step(); snap = 1'b0;
    rd_chk("post-stop ev0", 0, 0, 20);
    rd_chk("post-stop ev1", 0, 1, 0);
    chk("post-stop stopped", longint'(stop_v[0]), 1);
    idle_inputs();

    // Overflow: 17 pulses on bit 0 into 4-bit counters
    clear = 1'b1; step(); clear = 1'b0;
    for (int i = 0; i < 17; i++) begin en = 1'b1; ev = 4'b0001; step(); end
    en = 1'b0; ev = '0; snap = 1'b1; step(); snap = 1'b0;
    rd_chk("sat count", 1, 0, 15);
    rd_chk("wrap count", 2, 0, 1);
    rd_chk("wide count", 0, 0, 17);
    chk("sat ovf0", longint'(ovf_v[1][0]), 1);
    chk("wrap ovf0", longint'(ovf_v[2][0]), 1);
    chk("wide ovf0", longint'(ovf_v[0][0]), 0);

    // Reset while STOPPED with counts of 7
    clear = 1'b1; step(); clear = 1'b0;
    stop_pc = 32'h0000_0200; stop_en = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      en = 1'b1; ev = 4'b1111; pc = (i == 7) ? stop_pc : 32'h0000_0100;
      step();
    end
    rd_chk("pre-reset ev3", 0, 3, 7);
    chk("pre-reset stopped", longint'(stop_v[0]), 1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("post-reset stopped", longint'(stop_v[0]), 0);
    chk("post-reset overflow", longint'(ovf_v[1]), 0);
    rd_chk("post-reset sel7", 0, 7, 0);
    rd_chk("post-reset sel4", 0, 4, 0);
    idle_inputs();

    // Randomized stimulus against the model
    stop_pc = 32'h0000_0100;
    for (int i = 0; i < 2000; i++) begin
      reset   = ($urandom_range(0, 199) == 0);
      clear   = ($urandom_range(0, 63) == 0);
      en      = ($urandom_range(0, 7) != 0);
      ev      = 4'($urandom);
      snap    = ($urandom_range(0, 7) == 0);
      stop_en = ($urandom_range(0, 3) == 0);
      pc      = ($urandom_range(0, 15) == 0) ? stop_pc : $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
